reflet_regbank: RTL and testbench

- Parametrised register bank and write-back sequencer for the Reflet CPU core.
- Holds the 16 architectural registers: WR=0, SR=1, PC=2, SP=3, GP 4..15.
- Applies one decoded update per retired instruction, and handles PC increment, SP push/pop adjustment and the quit latch.
- Adds a hardware shadow stack that saves and restores WR/SR/PC on nested interrupt entry/return, so interrupt routines no longer spill context in software.

---
 rtl/reflet_regbank_pkg.sv | 22 ++
 rtl/reflet_shadow_stack.sv | 84 ++++++++
 rtl/reflet_regbank.sv | 127 ++++++++++++
 tb/tb_reflet_regbank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reflet_regbank_pkg.sv
// Shared definitions for the Reflet register bank: architectural register ids
// and the SP adjust encoding.
package reflet_regbank_pkg;

    localparam int unsigned NB_REGS   = 16;
    localparam int unsigned REG_IDX_W = 4;

    // Architectural register ids
    localparam logic [REG_IDX_W-1:0] WR_ID = 4'd0;
    localparam logic [REG_IDX_W-1:0] SR_ID = 4'd1;
    localparam logic [REG_IDX_W-1:0] PC_ID = 4'd2;
    localparam logic [REG_IDX_W-1:0] SP_ID = 4'd3;

    // SP adjust encoding; the reserved code behaves as no adjust
    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_INC  = 2'b01,
        SP_DEC  = 2'b10,
        SP_RSVD = 2'b11
    } sp_op_e;

endpackage

// File: rtl/reflet_shadow_stack.sv
// Hardware LIFO saving {WR, SR, PC} on interrupt entry and restoring it on
// return. Tracks nesting depth and latches a sticky error on overflow/underflow.
// Ports:
//   clk, reset      clock, async active-low reset
//   push, pop       requests (push has priority; caller keeps them exclusive)
//   push_data       context word {WR, SR, PC} to save
//   top_data        most recently saved context (valid when !empty)
//   depth           current nesting depth
//   full, empty     depth == nb_int_levels / depth == 0
//   error           sticky overflow/underflow flag
module reflet_shadow_stack #(
    parameter int unsigned wordsize      = 16,
    parameter int unsigned nb_int_levels = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [3*wordsize-1:0]                push_data,
    output logic [3*wordsize-1:0]                top_data,
    output logic [$clog2(nb_int_levels+1)-1:0]   depth,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 error
);

    localparam int unsigned DEPTH_W = $clog2(nb_int_levels + 1);
    localparam int unsigned ADDR_W  = (nb_int_levels > 1) ? $clog2(nb_int_levels) : 1;
    localparam int unsigned CTX_W   = 3 * wordsize;

    logic [CTX_W-1:0]   mem_q [nb_int_levels];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;

    assign full    = (depth_q == DEPTH_W'(nb_int_levels));
    assign empty   = (depth_q == '0);
    assign wr_addr = ADDR_W'(depth_q);
    assign rd_addr = ADDR_W'(depth_q - DEPTH_W'(1));

    // Depth/error next state; a rejected push or pop only raises the error
    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        if (push) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q + DEPTH_W'(1);
                wr_en   = 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Context storage; contents are meaningless after reset so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_data;
        end
    end

    assign top_data = mem_q[rd_addr];
    assign depth    = depth_q;
    assign error    = err_q;

endmodule

// File: rtl/reflet_regbank.sv
// Reflet CPU register bank and write-back sequencer: 16 architectural
// registers, PC step, SP push/pop adjust, quit latch and a hardware shadow
// stack for nested interrupt context.
// Ports:
//   clk, reset                  clock, async active-low reset
//   enable, stall               update gating (update when enable && !stall && !quit)
//   wr_valid/wr_index/wr_content  general register write
//   sp_op                       SP adjust (none / inc / dec / reserved)
//   quit_req                    quit instruction retiring
//   int_enter/int_routine       interrupt entry and handler address
//   int_return                  return from interrupt
//   rd_index/rd_data            combinational read port
//   wr_out, sr_out, pc_out, sp_out  special register views
//   quit, int_depth, shadow_err status
module reflet_regbank
    import reflet_regbank_pkg::*;
#(
    parameter int unsigned wordsize      = 16,
    parameter int unsigned nb_int_levels = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 stall,
    input  logic                                 wr_valid,
    input  logic [3:0]                           wr_index,
    input  logic [wordsize-1:0]                  wr_content,
    input  logic [1:0]                           sp_op,
    input  logic                                 quit_req,
    input  logic                                 int_enter,
    input  logic [wordsize-1:0]                  int_routine,
    input  logic                                 int_return,
    input  logic [3:0]                           rd_index,
    output logic [wordsize-1:0]                  rd_data,
    output logic [wordsize-1:0]                  wr_out,
    output logic [wordsize-1:0]                  sr_out,
    output logic [wordsize-1:0]                  pc_out,
    output logic [wordsize-1:0]                  sp_out,
    output logic                                 quit,
    output logic [$clog2(nb_int_levels+1)-1:0]   int_depth,
    output logic                                 shadow_err
);

    localparam int unsigned CTX_W = 3 * wordsize;
    localparam logic [wordsize-1:0] SP_STEP = wordsize'(wordsize / 8);
    localparam logic [wordsize-1:0] PC_STEP = wordsize'(1);

    logic [wordsize-1:0] regs_q [NB_REGS];
    logic [wordsize-1:0] regs_d [NB_REGS];
    logic                quit_q, quit_d;

    logic                upd, push, pop, do_enter, do_return, normal;
    logic                stk_full, stk_empty;
    logic [CTX_W-1:0]    stk_top, stk_push_data;

    // An overflowed entry or underflowed return falls through to a normal update
    assign upd       = enable & ~stall & ~quit_q;
    assign push      = upd & int_enter;
    assign pop       = upd & ~int_enter & int_return;
    assign do_enter  = push & ~stk_full;
    assign do_return = pop & ~stk_empty;
    assign normal    = upd & ~do_enter & ~do_return;

    assign stk_push_data = {regs_q[WR_ID], regs_q[SR_ID], regs_q[PC_ID]};

    reflet_shadow_stack #(
        .wordsize      (wordsize),
        .nb_int_levels (nb_int_levels)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (stk_push_data),
        .top_data  (stk_top),
        .depth     (int_depth),
        .full      (stk_full),
        .empty     (stk_empty),
        .error     (shadow_err)
    );

    // Register next state; explicit write is applied last so it beats SP/PC stepping
    always_comb begin
        regs_d = regs_q;
        quit_d = quit_q;
        if (do_enter) begin
            regs_d[PC_ID] = int_routine;
        end else if (do_return) begin
            regs_d[WR_ID] = stk_top[3*wordsize-1:2*wordsize];
            regs_d[SR_ID] = stk_top[2*wordsize-1:wordsize];
            regs_d[PC_ID] = stk_top[wordsize-1:0];
        end else if (normal) begin
            if (quit_req) begin
                quit_d = 1'b1;
            end
            case (sp_op_e'(sp_op))
                SP_INC:  regs_d[SP_ID] = regs_q[SP_ID] + SP_STEP;
                SP_DEC:  regs_d[SP_ID] = regs_q[SP_ID] - SP_STEP;
                default: ;
            endcase
            regs_d[PC_ID] = regs_q[PC_ID] + PC_STEP;
            if (wr_valid) begin
                regs_d[wr_index] = wr_content;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NB_REGS; i++) begin
                regs_q[i] <= '0;
            end
            quit_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            quit_q <= quit_d;
        end
    end

    assign rd_data = regs_q[rd_index];
    assign wr_out  = regs_q[WR_ID];
    assign sr_out  = regs_q[SR_ID];
    assign pc_out  = regs_q[PC_ID];
    assign sp_out  = regs_q[SP_ID];
    assign quit    = quit_q;

endmodule

// File: tb/tb_reflet_regbank.sv
// Directed bench for reflet_regbank (wordsize=16, nb_int_levels=2).
module tb_reflet_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, stall, wr_valid, quit_req, int_enter, int_return;
    logic [3:0]  wr_index, rd_index;
    logic [15:0] wr_content, int_routine;
    logic [1:0]  sp_op;
    logic [15:0] rd_data, wr_out, sr_out, pc_out, sp_out;
    logic        quit, shadow_err;
    logic [1:0]  int_depth;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    reflet_regbank #(.wordsize(16), .nb_int_levels(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_content(wr_content),
        .sp_op(sp_op), .quit_req(quit_req), .int_enter(int_enter),
        .int_routine(int_routine), .int_return(int_return),
        .rd_index(rd_index), .rd_data(rd_data),
        .wr_out(wr_out), .sr_out(sr_out), .pc_out(pc_out), .sp_out(sp_out),
        .quit(quit), .int_depth(int_depth), .shadow_err(shadow_err)
    );

    task automatic idle_inputs();
        stall = 1'b0; wr_valid = 1'b0; wr_index = 4'd0; wr_content = 16'h0;
        sp_op = 2'b00; quit_req = 1'b0; int_enter = 1'b0; int_routine = 16'h0;
        int_return = 1'b0;
    endtask

    // One active edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Reset with enable low so the release edge applies nothing
    task automatic do_reset();
        enable = 1'b0;
        idle_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] val);
        wr_valid = 1'b1; wr_index = idx; wr_content = val;
        tick();
    endtask

    task automatic enter(input logic [15:0] routine);
        int_enter = 1'b1; int_routine = routine;
        tick();
    endtask

    task automatic test_reset();
        enable = 1'b0; idle_inputs(); rd_index = 4'd0;
        reset = 1'b0;
        #3;
        vec_cnt++; if (pc_out !== 16'h0) begin err_cnt++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 16'h0); end
        vec_cnt++; if ({quit, shadow_err, int_depth} !== 4'b0) begin err_cnt++; $display("FAIL reset_status got=%b exp=0000", {quit, shadow_err, int_depth}); end
        reset = 1'b1;
        @(posedge clk); #1; enable = 1'b1;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        wr(4'd5, 16'h1234);
        enter(16'h0100);
        enter(16'h0200);
        rd_index = 4'd5; #1;
        vec_cnt++; if (rd_data !== 16'h1234 || int_depth !== 2'd2) begin err_cnt++; $display("FAIL midrun_load gp5=%h depth=%0d exp 1234/2", rd_data, int_depth); end
        reset = 1'b0; #1;
        vec_cnt++; if (rd_data !== 16'h0) begin err_cnt++; $display("FAIL midrun_gp5 got=%h exp=0000", rd_data); end
        vec_cnt++; if (pc_out !== 16'h0 || wr_out !== 16'h0) begin err_cnt++; $display("FAIL midrun_pc_wr pc=%h wr=%h exp 0/0", pc_out, wr_out); end
        vec_cnt++; if (int_depth !== 2'd0 || shadow_err !== 1'b0 || quit !== 1'b0) begin err_cnt++; $display("FAIL midrun_status depth=%0d err=%b quit=%b exp 0/0/0", int_depth, shadow_err, quit); end
        enable = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_write_pc();
        do_reset();
        wr(4'd2, 16'h0010);
        vec_cnt++; if (pc_out !== 16'h0010) begin err_cnt++; $display("FAIL pc_load got=%h exp=0010", pc_out); end
        wr(4'd4, 16'hBEEF);
        rd_index = 4'd4; #1;
        vec_cnt++; if (rd_data !== 16'hBEEF) begin err_cnt++; $display("FAIL gp_write got=%h exp=BEEF", rd_data); end
        vec_cnt++; if (pc_out !== 16'h0011) begin err_cnt++; $display("FAIL pc_step got=%h exp=0011", pc_out); end
        wr(4'd2, 16'h0040);
        vec_cnt++; if (pc_out !== 16'h0040) begin err_cnt++; $display("FAIL pc_write_no_inc got=%h exp=0040", pc_out); end
    endtask

    task automatic test_sp();
        do_reset();
        sp_op = 2'b10; tick();
        vec_cnt++; if (sp_out !== 16'hFFFE) begin err_cnt++; $display("FAIL sp_dec_wrap got=%h exp=FFFE", sp_out); end
        sp_op = 2'b01; tick();
        vec_cnt++; if (sp_out !== 16'h0000) begin err_cnt++; $display("FAIL sp_inc_wrap got=%h exp=0000", sp_out); end
        sp_op = 2'b01; wr(4'd3, 16'h0100);
        vec_cnt++; if (sp_out !== 16'h0100) begin err_cnt++; $display("FAIL sp_write_wins got=%h exp=0100", sp_out); end
        sp_op = 2'b11; tick();
        vec_cnt++; if (sp_out !== 16'h0100 || pc_out !== 16'h0004) begin err_cnt++; $display("FAIL sp_reserved sp=%h pc=%h exp 0100/0004", sp_out, pc_out); end
    endtask

    task automatic test_nesting();
        do_reset();
        wr(4'd0, 16'h0001);
        wr(4'd1, 16'h0002);
        wr(4'd2, 16'h0003);
        enter(16'h0200);
        vec_cnt++; if (pc_out !== 16'h0200 || int_depth !== 2'd1) begin err_cnt++; $display("FAIL enter1 pc=%h depth=%0d exp 0200/1", pc_out, int_depth); end
        wr(4'd0, 16'h0007);
        // Entry outranks a same-cycle write
        wr_valid = 1'b1; wr_index = 4'd6; wr_content = 16'hAAAA;
        enter(16'h0300);
        rd_index = 4'd6; #1;
        vec_cnt++; if (pc_out !== 16'h0300 || int_depth !== 2'd2) begin err_cnt++; $display("FAIL enter2 pc=%h depth=%0d exp 0300/2", pc_out, int_depth); end
        vec_cnt++; if (rd_data !== 16'h0 || wr_out !== 16'h0007) begin err_cnt++; $display("FAIL enter2_nowrite r6=%h wr=%h exp 0000/0007", rd_data, wr_out); end
        // Return ignores write, SP adjust and quit in the same cycle
        int_return = 1'b1; wr_valid = 1'b1; wr_index = 4'd6; wr_content = 16'h5555;
        sp_op = 2'b01; quit_req = 1'b1;
        tick();
        vec_cnt++; if ({wr_out, sr_out, pc_out} !== {16'h0007, 16'h0002, 16'h0201}) begin err_cnt++; $display("FAIL return1 wr=%h sr=%h pc=%h exp 0007/0002/0201", wr_out, sr_out, pc_out); end
        vec_cnt++; if (rd_data !== 16'h0 || sp_out !== 16'h0 || quit !== 1'b0 || int_depth !== 2'd1) begin err_cnt++; $display("FAIL return1_ignored r6=%h sp=%h quit=%b depth=%0d exp 0/0/0/1", rd_data, sp_out, quit, int_depth); end
        int_return = 1'b1; tick();
        vec_cnt++; if ({wr_out, sr_out, pc_out} !== {16'h0001, 16'h0002, 16'h0003}) begin err_cnt++; $display("FAIL return2 wr=%h sr=%h pc=%h exp 0001/0002/0003", wr_out, sr_out, pc_out); end
        vec_cnt++; if (int_depth !== 2'd0 || shadow_err !== 1'b0) begin err_cnt++; $display("FAIL return2_status depth=%0d err=%b exp 0/0", int_depth, shadow_err); end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        enter(16'h0100);
        enter(16'h0200);
        vec_cnt++; if (shadow_err !== 1'b0) begin err_cnt++; $display("FAIL pre_overflow_err got=%b exp=0", shadow_err); end
        enter(16'h0500);
        vec_cnt++; if (pc_out !== 16'h0201 || int_depth !== 2'd2) begin err_cnt++; $display("FAIL overflow pc=%h depth=%0d exp 0201/2", pc_out, int_depth); end
        vec_cnt++; if (shadow_err !== 1'b1) begin err_cnt++; $display("FAIL overflow_err got=%b exp=1", shadow_err); end
        do_reset();
        int_return = 1'b1; tick();
        vec_cnt++; if (shadow_err !== 1'b1 || pc_out !== 16'h0001 || int_depth !== 2'd0) begin err_cnt++; $display("FAIL underflow err=%b pc=%h depth=%0d exp 1/0001/0", shadow_err, pc_out, int_depth); end
    endtask

    task automatic test_stall_quit();
        do_reset();
        stall = 1'b1; wr(4'd4, 16'h0055);
        rd_index = 4'd4; #1;
        vec_cnt++; if (rd_data !== 16'h0 || pc_out !== 16'h0) begin err_cnt++; $display("FAIL stall_hold r4=%h pc=%h exp 0/0", rd_data, pc_out); end
        enable = 1'b0; wr(4'd4, 16'h0066); enable = 1'b1;
        vec_cnt++; if (rd_data !== 16'h0 || pc_out !== 16'h0) begin err_cnt++; $display("FAIL enable_hold r4=%h pc=%h exp 0/0", rd_data, pc_out); end
        wr(4'd2, 16'h0005);
        quit_req = 1'b1; tick();
        vec_cnt++; if (quit !== 1'b1 || pc_out !== 16'h0006) begin err_cnt++; $display("FAIL quit quit=%b pc=%h exp 1/0006", quit, pc_out); end
        enter(16'h0700);
        vec_cnt++; if (pc_out !== 16'h0006 || int_depth !== 2'd0) begin err_cnt++; $display("FAIL quit_no_int pc=%h depth=%0d exp 0006/0", pc_out, int_depth); end
        wr(4'd4, 16'h0099);
        vec_cnt++; if (rd_data !== 16'h0 || quit !== 1'b1) begin err_cnt++; $display("FAIL quit_no_write r4=%h quit=%b exp 0/1", rd_data, quit); end
        do_reset();
        vec_cnt++; if (quit !== 1'b0) begin err_cnt++; $display("FAIL quit_cleared got=%b exp=0", quit); end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_write_pc();
        test_sp();
        test_nesting();
        test_overflow_underflow();
        test_stall_quit();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
